// File: rtl/delay_line_pkg.sv
// delay_line_pkg
//   Shared definitions for the delay_line_pipe slice: legal depth limits,
//   the {valid, data} stage record and a depth legality helper.
//   Optional feature macro used by the slice: DELAY_LINE_BYPASS_EN.
package delay_line_pkg;

  localparam int MAX_DEPTH_MIN = 2;
  localparam int MAX_DEPTH_MAX = 64;
  localparam int DEFAULT_WIDTH = 32;

  // One pipeline stage at the default data width; valid sits in the MSB.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } stage_t;

  function automatic bit depth_legal(int depth);
    return (depth >= MAX_DEPTH_MIN) && (depth <= MAX_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/delay_line_stage.sv
// delay_line_stage
//   One {valid, data} register of the delay line. Synchronous active-high
//   reset, then flush, then enable; with en=0 the stage holds.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous reset, active high
//   en         - load enable
//   flush      - clear contents at the next edge
//   prev_valid - valid bit from the previous stage (or the input)
//   prev_data  - data from the previous stage (or the input)
//   valid      - registered valid bit
//   data       - registered data
module delay_line_stage
  import delay_line_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= prev_valid;
      data  <= prev_data;
    end
  end

endmodule

// File: rtl/delay_line_pipe.sv
// delay_line_pipe
//   Runtime-selectable delay line of MAX_DEPTH {valid, data} stages. The
//   output is a tap mux onto stage (delay_sel-1); delay_sel is clamped to
//   MAX_DEPTH and 0 is treated as 1. A saturating fill counter drives
//   primed once enough enabled cycles have passed since reset/flush.
//   Macro DELAY_LINE_BYPASS_EN: when defined, delay_sel=0 routes in_* to
//   out_* combinationally and forces primed=1.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous reset, active high (priority over flush, en)
//   en        - shift enable; 0 freezes stages and fill counter
//   flush     - clears stages and fill counter (priority over en)
//   delay_sel - requested delay in enabled cycles
//   in_valid  - input qualifier
//   in_data   - input data
//   out_valid - valid of selected tap
//   out_data  - data of selected tap
//   primed    - selected depth has been filled since reset/flush
module delay_line_pipe
  import delay_line_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_DEPTH = 8,
  parameter int SEL_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [SEL_W-1:0] delay_sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             primed
);

  localparam int CNT_W = $clog2(MAX_DEPTH + 1);
  localparam int IDX_W = $clog2(MAX_DEPTH);

  if (!depth_legal(MAX_DEPTH)) begin : g_bad_depth
    $error("delay_line_pipe: MAX_DEPTH out of range");
  end

  logic [MAX_DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0]     stage_data [MAX_DEPTH];
  logic [CNT_W-1:0]     fill_cnt;
  logic [CNT_W-1:0]     eff_depth;
  logic [IDX_W-1:0]     tap;

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    logic             prev_valid;
    logic [WIDTH-1:0] prev_data;

    if (k == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_data  = in_data;
    end else begin : g_tail
      assign prev_valid = stage_valid[k-1];
      assign prev_data  = stage_data[k-1];
    end

    delay_line_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .prev_valid(prev_valid),
      .prev_data (prev_data),
      .valid     (stage_valid[k]),
      .data      (stage_data[k])
    );
  end

  // Fill counter saturates at MAX_DEPTH so primed stays valid for any tap.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      fill_cnt <= '0;
    end else if (en && (fill_cnt != CNT_W'(MAX_DEPTH))) begin
      fill_cnt <= fill_cnt + CNT_W'(1);
    end
  end

  // Effective depth in 1..MAX_DEPTH; compare in 32 bits so an oversized
  // delay_sel clamps instead of wrapping.
  always_comb begin
    if (32'(delay_sel) > 32'(MAX_DEPTH)) begin
      eff_depth = CNT_W'(MAX_DEPTH);
    end else if (delay_sel == '0) begin
      eff_depth = CNT_W'(1);
    end else begin
      eff_depth = CNT_W'(delay_sel);
    end
  end

  assign tap = IDX_W'(eff_depth - CNT_W'(1));

  always_comb begin
    out_valid = stage_valid[tap];
    out_data  = stage_data[tap];
    primed    = (fill_cnt >= eff_depth);
`ifdef DELAY_LINE_BYPASS_EN
    if (delay_sel == '0) begin
      out_valid = in_valid;
      out_data  = in_data;
      primed    = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_delay_line_pipe.sv
// tb_delay_line_pipe
//   Directed bench for delay_line_pipe (WIDTH=32, MAX_DEPTH=8). Inputs are
//   driven 1 time unit after the rising edge and outputs sampled there too.
module tb_delay_line_pipe;

  localparam int WIDTH = 32;
  localparam int MAX_DEPTH = 8;
  localparam int SEL_W = $clog2(MAX_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic [SEL_W-1:0] delay_sel;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             primed;

  int n_checks = 0;
  int n_pass   = 0;

  delay_line_pipe #(
    .WIDTH    (WIDTH),
    .MAX_DEPTH(MAX_DEPTH),
    .SEL_W    (SEL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .delay_sel(delay_sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .primed   (primed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    delay_sel = 4'd1;
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++;
    if (out_data !== 32'd0) $display("FAIL reset_data: got %0d want 0", out_data); else n_pass++;
    n_checks++;
    if (primed !== 1'b0) $display("FAIL reset_primed: got %b want 0", primed); else n_pass++;
    delay_sel = 4'd8; #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || primed !== 1'b0)
      $display("FAIL reset_sel8: got v=%b d=%0d p=%b want 0/0/0", out_valid, out_data, primed);
    else n_pass++;
  endtask

  task automatic test_delay1();
    delay_sel = 4'd1;
    do_reset();
    in_valid = 1'b1; in_data = 32'd10034; en = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0)
      $display("FAIL delay1_before: got v=%b d=%0d want 0/0", out_valid, out_data);
    else n_pass++;
    tick();
    n_checks++;
    if (out_data !== 32'd10034) $display("FAIL delay1_data: got %0d want 10034", out_data); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL delay1_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++;
    if (primed !== 1'b1) $display("FAIL delay1_primed: got %b want 1", primed); else n_pass++;
    en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stream5();
    delay_sel = 4'd5;
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      in_data = 32'(i);
      tick();
      n_checks++;
      if (out_data !== ((i >= 5) ? 32'(i - 4) : 32'd0) || out_valid !== (i >= 5))
        $display("FAIL stream5_out[%0d]: got v=%b d=%0d want v=%b d=%0d", i, out_valid, out_data,
                 (i >= 5), (i >= 5) ? i - 4 : 0);
      else n_pass++;
      n_checks++;
      if (primed !== (i >= 5)) $display("FAIL stream5_primed[%0d]: got %b want %b", i, primed, (i >= 5));
      else n_pass++;
    end
    en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_stall();
    delay_sel = 4'd4;
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_data = 32'(i);
      tick();
    end
    en = 1'b0; in_data = 32'd99; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (out_data !== 32'd3 || out_valid !== 1'b1 || primed !== 1'b1)
        $display("FAIL stall_frozen[%0d]: got v=%b d=%0d p=%b want 1/3/1", c, out_valid, out_data, primed);
      else n_pass++;
    end
    en = 1'b1; in_valid = 1'b1;
    for (int i = 7; i <= 10; i++) begin
      in_data = 32'(i);
      tick();
      n_checks++;
      if (out_data !== 32'(i - 3) || out_valid !== 1'b1)
        $display("FAIL stall_resume[%0d]: got v=%b d=%0d want 1/%0d", i, out_valid, out_data, i - 3);
      else n_pass++;
    end
    en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_flush();
    delay_sel = 4'd8;
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 32'(i);
      tick();
    end
    n_checks++;
    if (out_data !== 32'd3 || primed !== 1'b1)
      $display("FAIL flush_full: got d=%0d p=%b want 3/1", out_data, primed);
    else n_pass++;
    flush = 1'b1; in_data = 32'd555;
    tick();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || primed !== 1'b0)
      $display("FAIL flush_clear: got v=%b d=%0d p=%b want 0/0/0", out_valid, out_data, primed);
    else n_pass++;
    in_data = 32'd99009900; in_valid = 1'b1;
    tick();
    in_data = 32'd0; in_valid = 1'b0;
    for (int e = 2; e <= 7; e++) tick();
    n_checks++;
    if (out_valid !== 1'b0 || primed !== 1'b0)
      $display("FAIL flush_edge7: got v=%b p=%b want 0/0", out_valid, primed);
    else n_pass++;
    tick();
    n_checks++;
    if (out_data !== 32'd99009900 || out_valid !== 1'b1 || primed !== 1'b1)
      $display("FAIL flush_edge8: got v=%b d=%0d p=%b want 1/99009900/1", out_valid, out_data, primed);
    else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_clamp();
    delay_sel = 4'd12;
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 32'(i);
      tick();
      if (i == 7) begin
        n_checks++;
        if (out_valid !== 1'b0 || primed !== 1'b0)
          $display("FAIL clamp_edge7: got v=%b p=%b want 0/0", out_valid, primed);
        else n_pass++;
      end
    end
    en = 1'b0; in_valid = 1'b1; in_data = 32'd777;
    #1;
    n_checks++;
    if (out_data !== 32'd3 || out_valid !== 1'b1 || primed !== 1'b1)
      $display("FAIL clamp_sel12: got v=%b d=%0d p=%b want 1/3/1", out_valid, out_data, primed);
    else n_pass++;
    delay_sel = 4'd8; #1;
    n_checks++;
    if (out_data !== 32'd3) $display("FAIL clamp_sel8: got %0d want 3", out_data); else n_pass++;
    delay_sel = 4'd0; #1;
`ifdef DELAY_LINE_BYPASS_EN
    n_checks++;
    if (out_data !== 32'd777 || out_valid !== 1'b1 || primed !== 1'b1)
      $display("FAIL clamp_sel0: got v=%b d=%0d p=%b want 1/777/1", out_valid, out_data, primed);
    else n_pass++;
`else
    n_checks++;
    if (out_data !== 32'd10 || out_valid !== 1'b1 || primed !== 1'b1)
      $display("FAIL clamp_sel0: got v=%b d=%0d p=%b want 1/10/1", out_valid, out_data, primed);
    else n_pass++;
`endif
    delay_sel = 4'd1; #1;
    n_checks++;
    if (out_data !== 32'd10) $display("FAIL clamp_sel1: got %0d want 10", out_data); else n_pass++;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_priority();
    delay_sel = 4'd1;
    rst = 1'b1; flush = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 32'd1234;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || primed !== 1'b0)
      $display("FAIL rstprio_hold: got v=%b d=%0d p=%b want 0/0/0", out_valid, out_data, primed);
    else n_pass++;
    rst = 1'b0; flush = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    n_checks++;
    if (primed !== 1'b0) $display("FAIL rstprio_primed: got %b want 0", primed); else n_pass++;
    delay_sel = 4'd8; #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0)
      $display("FAIL rstprio_sel8: got v=%b d=%0d want 0/0", out_valid, out_data);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; delay_sel = '0; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_delay1();
    test_stream5();
    test_stall();
    test_flush();
    test_clamp();
    test_reset_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/delay_line_pipe.md
DELAY_LINE_PIPE -- requirements
Module: delay_line_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter MAX_DEPTH, default 8, number of register stages, legal range 2..64.
REQ-003 SHALL have parameter SEL_W, default $clog2(MAX_DEPTH+1), width of delay_sel.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1, shift enable; 0 stalls all stages.
REQ-007 SHALL have port flush, input, 1, clears pipeline contents and valid bits.
REQ-008 SHALL have port delay_sel, input, SEL_W, runtime delay in cycles.
REQ-009 SHALL have port in_valid, input, 1, qualifies in_data.
REQ-010 SHALL have port in_data, input, WIDTH, data to delay.
REQ-011 SHALL have port out_valid, output, 1, valid of selected tap.
REQ-012 SHALL have port out_data, output, WIDTH, data of selected tap.
REQ-013 SHALL have port primed, output, 1, high once the selected depth has been filled since reset/flush.

Function
REQ-014 SHALL hold MAX_DEPTH stages of {valid, data}; on en=1, stage0 <= {in_valid, in_data} and stage k <= stage k-1.
REQ-015 SHALL drive out_valid/out_data combinationally from stage (delay_sel-1); delay of N enabled cycles for delay_sel=N.
REQ-016 SHALL clamp delay_sel > MAX_DEPTH to MAX_DEPTH.
REQ-017 SHALL treat delay_sel=0 as 1 unless DELAY_LINE_BYPASS_EN is defined (REQ-027).
REQ-018 SHALL apply a delay_sel change in the same cycle (tap mux only); stage contents are not altered, so samples may be skipped or repeated.
REQ-019 SHALL, with en=0, hold all stages, fill count and outputs unchanged.
REQ-020 SHALL keep a fill counter, 0..MAX_DEPTH, incremented on each en=1 cycle, saturating at MAX_DEPTH.
REQ-021 SHALL drive primed = (fill counter >= effective delay_sel); recomputed combinationally on delay_sel change.
REQ-022 SHALL, on flush=1, clear all valid bits, data to 0 and fill counter to 0 at the next edge, ignoring en and in_*.
REQ-023 SHALL give priority rst > flush > en.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, clear all stage data and valid bits to 0 and the fill counter to 0.
REQ-025 SHALL present out_valid=0, out_data=0, primed=0 after reset for any delay_sel >= 1.
REQ-026 SHALL allow reset mid-operation; all in-flight samples are discarded with no output of partial data.

Configuration
REQ-027 SHALL, with DELAY_LINE_BYPASS_EN defined, pass in_valid/in_data combinationally to outputs when delay_sel=0 and drive primed=1.
REQ-028 SHALL, without DELAY_LINE_BYPASS_EN, contain no combinational in-to-out path.

Structure
REQ-029 SHALL place the MAX_DEPTH legal limits and a stage typedef {valid, data} helper in package delay_line_pkg.
REQ-030 SHALL instantiate sub-module delay_line_stage (one enabled, flushable, sync-reset register) MAX_DEPTH times.

Verification
REQ-031 SHALL cover: rst 1 cycle, delay_sel=1, in_data=10034 valid -> out_data=10034, out_valid=1 after 1 enabled edge; 0 before.
REQ-032 SHALL cover: delay_sel=5, stream 1,2,3... -> out_data equals input from 5 edges earlier; primed rises on 5th edge.
REQ-033 SHALL cover: delay_sel=4, en=0 for 3 cycles mid-stream -> outputs frozen, sequence resumes with no gap or duplicate.
REQ-034 SHALL cover: flush with pipe full, delay_sel=8 -> next cycle out_valid=0, out_data=0, primed=0; 99009900 emerges 8 edges later.
REQ-035 SHALL cover: delay_sel=12 with MAX_DEPTH=8 -> behaves as 8; delay_sel=0 -> behaves as 1 (no macro) or zero-latency (macro).
REQ-036 SHALL cover: rst asserted with flush=1 and en=1 -> state equals reset state; rst deasserted -> primed=0.
